// File: rtl/dac_pair_tx_if.sv
// Sample-pair stream in, interleaved two-channel DAC bus out.
// The DAC transmitter takes the slave side; the source/bus model takes the master side.
interface dac_pair_tx_if #(
  parameter int DW  = 14,
  parameter int IW  = 16,
  parameter int UCW = 16
);
  logic                 en_i;
  logic signed [IW-1:0] cha_i;
  logic signed [IW-1:0] chb_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [DW-1:0]        dac_dat_o;
  logic                 dac_sel_o;
  logic                 dac_wrt_o;
  logic                 dac_rst_o;
  logic                 underflow_o;
  logic [UCW-1:0]       underflow_cnt_o;

  modport slave (
    input  en_i, cha_i, chb_i, valid_i,
    output ready_o, dac_dat_o, dac_sel_o, dac_wrt_o, dac_rst_o,
           underflow_o, underflow_cnt_o
  );

  modport master (
    output en_i, cha_i, chb_i, valid_i,
    input  ready_o, dac_dat_o, dac_sel_o, dac_wrt_o, dac_rst_o,
           underflow_o, underflow_cnt_o
  );
endinterface

// File: rtl/dac_pair_tx.sv
// Interleaved two-channel DAC transmitter: pair FIFO, saturate + offset-binary
// conversion on write, A/B time multiplexing with underflow repeat.
module dac_pair_tx #(
  parameter int DW         = 14,
  parameter int IW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYC    = 16,
  parameter int UCW        = 16
) (
  input  logic         dac_clk_i,
  input  logic         dac_rstn_i,
  dac_pair_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RST_CYC + 1);
  localparam logic [DW-1:0]        MID  = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [IW-1:0] SMAX = IW'((2 ** (DW-1)) - 1);
  localparam logic signed [IW-1:0] SMIN = ~SMAX;

  function automatic logic [DW-1:0] to_ob(input logic signed [IW-1:0] x);
    logic [DW-1:0] s;
    if (x > SMAX)      s = {1'b0, {(DW-1){1'b1}}};
    else if (x < SMIN) s = {1'b1, {(DW-1){1'b0}}};
    else               s = x[DW-1:0];
    return s ^ MID;
  endfunction

  typedef enum logic [1:0] {RST, IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic            ph_q, ph_d;
  logic            dis_q, dis_d;
  logic            ne_q;
  logic [2*DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q;
  logic            ready, push, pop, flush;
  logic [2*DW-1:0] cur_q, cur_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            sel_q, sel_d, wrt_q, wrt_d, rsto_q, rsto_d, uf_q, uf_d;
  logic [UCW-1:0]  ucnt_q, ucnt_d;

  assign ready = bus.en_i && (cnt_q != (AW+1)'(FIFO_DEPTH)) && (state_q != RST);
  assign push  = bus.valid_i && ready && !flush;

  // ph_q = 1 marks the B cycle, so the edge ending it is a pair boundary.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    ph_d    = ~ph_q;
    dis_d   = dis_q;
    pop     = 1'b0;
    flush   = 1'b0;
    cur_d   = cur_q;
    dat_d   = cur_q[DW-1:0];
    sel_d   = 1'b0;
    wrt_d   = 1'b1;
    rsto_d  = 1'b0;
    uf_d    = 1'b0;
    ucnt_d  = ucnt_q;
    unique case (state_q)
      RST: begin
        ph_d  = 1'b0;
        dat_d = MID;
        sel_d = 1'b1;
        wrt_d = 1'b0;
        cur_d = {MID, MID};
        if (rcnt_q == CW'(RST_CYC)) state_d = IDLE;
        else begin
          rcnt_d = rcnt_q + 1'b1;
          rsto_d = 1'b1;
        end
      end
      IDLE: if (ph_q) begin
        sel_d = 1'b1;
        wrt_d = 1'b0;
        if (bus.en_i && ne_q) begin
          pop     = 1'b1;
          cur_d   = mem[rp_q];
          dat_d   = mem[rp_q][2*DW-1:DW];
          state_d = RUN;
        end else begin
          cur_d = {MID, MID};
          dat_d = MID;
        end
      end
      RUN: if (!ph_q) begin
        // a disable seen anywhere in the pair takes effect at its boundary
        if (!bus.en_i) dis_d = 1'b1;
      end else begin
        sel_d = 1'b1;
        wrt_d = 1'b0;
        dis_d = 1'b0;
        if (!bus.en_i || dis_q) begin
          flush   = 1'b1;
          state_d = IDLE;
          cur_d   = {MID, MID};
          dat_d   = MID;
        end else if (ne_q) begin
          pop   = 1'b1;
          cur_d = mem[rp_q];
          dat_d = mem[rp_q][2*DW-1:DW];
        end else begin
          uf_d  = 1'b1;
          dat_d = cur_q[2*DW-1:DW];
          if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
        end
      end
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state_q <= RST;
      rcnt_q  <= '0;
      ph_q    <= 1'b0;
      dis_q   <= 1'b0;
      cur_q   <= {MID, MID};
      dat_q   <= MID;
      sel_q   <= 1'b1;
      wrt_q   <= 1'b0;
      rsto_q  <= 1'b1;
      uf_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      ph_q    <= ph_d;
      dis_q   <= dis_d;
      cur_q   <= cur_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      wrt_q   <= wrt_d;
      rsto_q  <= rsto_d;
      uf_q    <= uf_d;
      ucnt_q  <= ucnt_d;
    end
  end

  // ne_q lags the count by one edge: a pair is only poppable from the second
  // boundary-or-non-boundary edge after it was written.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ne_q  <= 1'b0;
    end else begin
      ne_q <= (cnt_q != '0);
      if (flush) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
        cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (push) mem[wp_q] <= {to_ob(bus.cha_i), to_ob(bus.chb_i)};
  end

  assign bus.ready_o         = ready;
  assign bus.dac_dat_o       = dat_q;
  assign bus.dac_sel_o       = sel_q;
  assign bus.dac_wrt_o       = wrt_q;
  assign bus.dac_rst_o       = rsto_q;
  assign bus.underflow_o     = uf_q;
  assign bus.underflow_cnt_o = ucnt_q;
endmodule

// File: tb/tb_dac_pair_tx.sv
// Scoreboard bench for dac_pair_tx: a queue-based pair model predicts every
// bus word, strobe and ready value; a monitor compares them each cycle.
module tb_dac_pair_tx;
  localparam int DW   = 14;
  localparam int IW   = 16;
  localparam int FD   = 4;
  localparam int RC   = 16;
  localparam int UCW  = 4;
  localparam int LIM  = 1 << (DW - 1);
  localparam int MIDV = LIM;
  localparam int UMAX = (1 << UCW) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dac_pair_tx_if #(.DW(DW), .IW(IW), .UCW(UCW)) bus ();

  dac_pair_tx #(.DW(DW), .IW(IW), .FIFO_DEPTH(FD), .RST_CYC(RC), .UCW(UCW)) dut (
    .dac_clk_i (clk),
    .dac_rstn_i(rstn),
    .bus       (bus)
  );

  typedef struct { int dat; bit sel; bit wrt; bit rst; bit uf; bit rdy; int ucnt; } obs_t;
  typedef struct { int a; int b; int e; } pair_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // offset binary of the clamped value, done with plain arithmetic
  function automatic int conv(input int x);
    int s;
    s = x;
    if (s > LIM - 1) s = LIM - 1;
    if (s < -LIM)    s = -LIM;
    return s + LIM;
  endfunction

  // Reference model: runs 2 time units after each edge, when the inputs for
  // the next edge are settled, and predicts the outputs after that edge.
  initial begin : model
    pair_t fq[$];
    pair_t cur;
    obs_t  nx;
    bit    inrst, run, dis, bnd, started, rdy, acc, en, flushed, avail;
    int    rel, ucnt, e;
    inrst = 1; run = 0; dis = 0; bnd = 0; started = 0;
    rel = 0; ucnt = 0; e = 0;
    cur = '{a: MIDV, b: MIDV, e: 0};
    nx  = '{dat: MIDV, sel: 1'b1, wrt: 1'b0, rst: 1'b1, uf: 1'b0, rdy: 1'b0, ucnt: 0};
    forever begin
      @(posedge clk); #2;
      e++;
      en  = bus.en_i;
      rdy = !inrst && en && (fq.size() < FD);
      if (started) begin
        nx.rdy = rdy;
        exp_q.push_back(nx);
      end
      started = 1;
      acc     = bus.valid_i && rdy;
      flushed = 0;
      nx.uf   = 1'b0;
      if (!rstn) begin
        inrst = 1; rel = 0; run = 0; dis = 0; ucnt = 0;
        fq.delete();
        cur = '{a: MIDV, b: MIDV, e: 0};
        nx  = '{dat: MIDV, sel: 1'b1, wrt: 1'b0, rst: 1'b1, uf: 1'b0, rdy: 1'b0, ucnt: 0};
      end else if (inrst) begin
        rel++;
        if (rel > RC) begin
          inrst = 0;
          bnd   = 0;
          nx    = '{dat: MIDV, sel: 1'b1, wrt: 1'b0, rst: 1'b0, uf: 1'b0, rdy: 1'b0, ucnt: ucnt};
        end
      end else begin
        if (bnd) begin
          avail = (fq.size() > 0) && (e - fq[0].e >= 2);
          if (run) begin
            if (!en || dis) begin
              run = 0; flushed = 1;
              fq.delete();
              cur = '{a: MIDV, b: MIDV, e: 0};
            end else if (avail) begin
              cur = fq.pop_front();
            end else begin
              nx.uf = 1'b1;
              if (ucnt < UMAX) ucnt++;
            end
          end else if (en && avail) begin
            cur = fq.pop_front();
            run = 1;
          end else begin
            cur = '{a: MIDV, b: MIDV, e: 0};
          end
          nx.dat = cur.a; nx.sel = 1'b1; nx.wrt = 1'b0;
          dis = 0; bnd = 0;
        end else begin
          if (run && !en) dis = 1;
          nx.dat = cur.b; nx.sel = 1'b0; nx.wrt = 1'b1;
          bnd = 1;
        end
        if (acc && !flushed)
          fq.push_back('{a: conv(int'(bus.cha_i)), b: conv(int'(bus.chb_i)), e: e});
        nx.rst  = 1'b0;
        nx.ucnt = ucnt;
      end
    end
  end

  initial begin : monitor
    obs_t ex;
    logic [DW+5+UCW-1:0] av, ev;
    forever begin
      @(posedge clk); #3;
      if (exp_q.size() != 0) begin
        ex = exp_q.pop_front();
        av = {bus.dac_dat_o, bus.dac_sel_o, bus.dac_wrt_o, bus.dac_rst_o,
              bus.underflow_o, bus.ready_o, bus.underflow_cnt_o};
        ev = {DW'(ex.dat), ex.sel, ex.wrt, ex.rst, ex.uf, ex.rdy, UCW'(ex.ucnt)};
        n_cmp++;
        if (av !== ev) begin
          n_bad++;
          $display("FAIL bus_cycle @%0t: got dat=%h sel=%b wrt=%b rst=%b uf=%b rdy=%b ucnt=%0d, want dat=%h sel=%b wrt=%b rst=%b uf=%b rdy=%b ucnt=%0d",
                   $time, bus.dac_dat_o, bus.dac_sel_o, bus.dac_wrt_o, bus.dac_rst_o,
                   bus.underflow_o, bus.ready_o, bus.underflow_cnt_o,
                   DW'(ex.dat), ex.sel, ex.wrt, ex.rst, ex.uf, ex.rdy, ex.ucnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int a, input int b);
    bit ok;
    ok = 0;
    bus.cha_i   = IW'(a);
    bus.chb_i   = IW'(b);
    bus.valid_i = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ready_o;
    end
    tick();
    bus.valid_i = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no ready in 200 cycles, want accept of (%0d,%0d)", a, b);
    end
  endtask

  initial begin : stim
    int rcount, p, thr;
    bit ok;
    bus.en_i = 1'b0; bus.valid_i = 1'b0; bus.cha_i = '0; bus.chb_i = '0;
    repeat (5) @(posedge clk);
    #1 rstn = 1'b1;

    // dac_rst_o must stay high for exactly RC cycles after release
    rcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.dac_rst_o) rcount++;
      else break;
    end
    n_cmp++;
    if (rcount != RC) begin
      n_bad++;
      $display("FAIL rst_len: got %0d cycles, want %0d", rcount, RC);
    end
    repeat (4) tick();

    // conversion corners, then underflow repeats of the last pair
    bus.en_i = 1'b1;
    send(0, -1);
    send(32767, -32768);
    send(8191, -8192);
    repeat (12) tick();

    // backpressure: valid held high, payload advances on each accept
    p = 1;
    bus.cha_i = IW'(p * 97); bus.chb_i = IW'(-p * 53); bus.valid_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ok = bus.ready_o;
      tick();
      if (ok) begin
        p++;
        bus.cha_i = IW'(p * 97); bus.chb_i = IW'(-p * 53);
      end
    end
    bus.valid_i = 1'b0;
    repeat (3) tick();

    // one-cycle disable inside an A cycle with pairs still queued
    for (int i = 0; i < 4; i++) begin
      if (bus.dac_sel_o) break;
      tick();
    end
    bus.en_i = 1'b0;
    tick();
    bus.en_i = 1'b1;
    repeat (10) tick();

    // long underflow run to drive the counter into saturation
    send(1234, -4321);
    repeat (50) tick();

    // random traffic with occasional disables
    for (int blk = 0; blk < 6; blk++) begin
      thr = $urandom_range(0, 4);
      for (int i = 0; i < 50; i++) begin
        bus.valid_i = ($urandom_range(0, 3) < thr);
        bus.en_i    = ($urandom_range(0, 19) != 0);
        bus.cha_i   = IW'($urandom);
        bus.chb_i   = IW'($urandom);
        tick();
      end
    end
    bus.valid_i = 1'b0;
    bus.en_i    = 1'b1;

    // reset asserted during a B cycle while streaming
    send(-100, 200);
    send(300, -400);
    for (int i = 0; i < 4; i++) begin
      if (!bus.dac_sel_o) break;
      tick();
    end
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (24) tick();
    send(5000, -5000);
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
